game_status_ctrl: RTL and testbench
===================================

# game_status_ctrl

Sequencer for the player-status datapath. It owns the current score, all-time high score, health and weapon cool-down registers, and runs a three-state game FSM (IDLE/PLAY/OVER). It arbitrates fire requests against the cool-down timer. It sits between the game-logic event strobes and the hex display drivers, which consume its 8-bit outputs directly as two nibbles each.

## Interface
- `TICK_DIV`, 25_000_000: clock cycles per cool-down tick.
- `COOL_LOAD`, 8'd5: ticks of cool-down loaded on each granted shot.
- `HEALTH_INIT`, 8'hFF: health loaded on game start.
- `clock`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begin a new game.
- `score_evt`  in  1  one-cycle pulse; enemy destroyed.
- `damage_evt`  in  1  one-cycle pulse; player hit.
- `fire_req`  in  1  level or pulse; player requests a shot.
- `fire_grant`  out  1  one-cycle pulse; shot accepted.
- `score`  out  8  current score, binary.
- `high_score`  out  8  all-time best score, binary.
- `health`  out  8  remaining health.
- `cooldown`  out  8  remaining cool-down ticks.
- `state`  out  2  IDLE=2'd0, PLAY=2'd1, OVER=2'd2.
- `game_over`  out  1  high while `state`==OVER.

## Operation
- Reset (async, `resetn`=0):
  - `state`=IDLE.
  - `score`=0, `high_score`=0, `health`=0, `cooldown`=0.
  - `fire_grant`=0, `game_over`=0.
  - Tick divider cleared.
- IDLE: all registers hold. `start` -> PLAY.
- PLAY:
  - `score_evt`: `score`+1, saturating at 8'hFF.
  - `damage_evt`:
    - `health` > 1: `health`-1.
    - `health` ≤ 1: `health`=0 and go to OVER.
  - `fire_req` with `cooldown`==0: `fire_grant` pulses and `cooldown`=COOL_LOAD.
  - `fire_req` with `cooldown`≠0: ignored. No queueing; the requester must re-assert.
  - Tick pulse: decrements `cooldown` if nonzero. Stops at 0 and never wraps.
- OVER:
  - On the entry edge, `high_score` = max(`high_score`, final `score`).
  - `score` and `health` hold.
  - `cooldown` forced to 0; fire requests ignored.
  - `start` -> PLAY.
- `start` from IDLE or OVER:
  - `score`=0, `health`=HEALTH_INIT, `cooldown`=0.
  - Tick divider restarts.
  - `high_score` is kept.
- `start` during PLAY is ignored.
- Simultaneous events in one PLAY cycle:
  - `score_evt` and `damage_evt` both apply.
  - If that damage is lethal, the high-score compare uses the incremented score.
  - Tick and granted fire in the same cycle: the load wins, so `cooldown`=COOL_LOAD.
  - Lethal damage and `fire_req` in the same cycle: the grant is suppressed.
- Tick divider:
  - Down-counter over TICK_DIV cycles, running only in PLAY.
  - Emits one pulse per TICK_DIV cycles, the first at cycle TICK_DIV after `start`.

## Timing
- All outputs are registered.
- Event-to-output latency is one clock: the output is updated on the edge that samples the strobe.
- `fire_grant` is high for exactly one cycle, on the edge that samples the qualifying `fire_req`.
- A held `fire_req` gets its next grant on the first edge where `cooldown`==0.
  - This is COOL_LOAD×TICK_DIV cycles after the previous grant, plus the tick phase.
- `game_over` and `state` change on the same edge as the lethal `damage_evt`.
- Reset asserted mid-game returns everything to reset values immediately, without waiting for `clock`.

## Structure
- Shared package `game_pkg`:
  - State enum (IDLE/PLAY/OVER).
  - Score/health width constant (8).
  - Default HEALTH_INIT and COOL_LOAD.
- Sub-module `tick_gen` (parameter TICK_DIV; ports `clock`, `resetn`, `enable`, `clear`, `tick`) holds the divider.
- FSM and the status registers live in the top module.

## Test plan
- **Start and score:** TICK_DIV=4. Reset, `start`, then 3 `score_evt` -> `score`=3, `health`=8'hFF, `state`=PLAY.
- **Saturation:** 300 `score_evt` pulses -> `score` stays 8'hFF. Then `health` of 1 plus one `damage_evt` -> OVER, `high_score`=8'hFF.
- **Cool-down arbitration:** COOL_LOAD=2, TICK_DIV=4, `fire_req` held high -> grants at cycles 1, 9, 17 after `start`; `cooldown` steps 2, 1, 0.
- **High-score retention:** HEALTH_INIT=2.
  - Game 1: 5 `score_evt`, then die -> `high_score`=5.
  - Game 2: `start` -> `score`=0, `high_score`=5. 3 `score_evt`, then die -> `high_score`=5.
- **Simultaneous lethal:** `health`=1, `score`=7, with `score_evt`, `damage_evt` and `fire_req` in one cycle -> `score`=8, `health`=0, OVER, `high_score`=8, no `fire_grant`.
- **Reset mid-game:** drop `resetn` between clock edges during PLAY with `cooldown`=3 -> all outputs 0 and `state`=IDLE immediately. After release, `start` restores `health`=8'hFF.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and defaults for the player-status datapath.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int            STAT_W           = 8;
  localparam logic [STAT_W-1:0] DEF_HEALTH_INIT = 8'hFF;
  localparam logic [STAT_W-1:0] DEF_COOL_LOAD   = 8'd5;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Cool-down tick divider: one pulse every TICK_DIV enabled cycles,
// the first TICK_DIV cycles after a clear.
module tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Tick fires on the cycle the counter has run down to zero.
  assign tick = enable && (r_cnt == '0);

  // Down-counter; clear re-phases it so the first tick lands TICK_DIV cycles out.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)         r_cnt <= '0;
    else if (clear)      r_cnt <= RELOAD;
    else if (enable) begin
      if (r_cnt == '0)   r_cnt <= RELOAD;
      else               r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/game_status_ctrl.sv
// Game status sequencer: IDLE/PLAY/OVER FSM owning score, high score,
// health and weapon cool-down, with fire arbitration against cool-down.
module game_status_ctrl
  import game_pkg::*;
#(
  parameter int                TICK_DIV    = 25_000_000,
  parameter logic [STAT_W-1:0] COOL_LOAD   = DEF_COOL_LOAD,
  parameter logic [STAT_W-1:0] HEALTH_INIT = DEF_HEALTH_INIT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              score_evt,
  input  logic              damage_evt,
  input  logic              fire_req,
  output logic              fire_grant,
  output logic [STAT_W-1:0] score,
  output logic [STAT_W-1:0] high_score,
  output logic [STAT_W-1:0] health,
  output logic [STAT_W-1:0] cooldown,
  output logic [1:0]        state,
  output logic              game_over
);

  state_e            r_state, w_state_nxt;
  logic [STAT_W-1:0] r_score, r_high, r_health, r_cool;
  logic              r_grant, r_game_over;

  logic [STAT_W-1:0] w_score_nxt, w_high_nxt, w_health_nxt, w_cool_nxt;
  logic [STAT_W-1:0] w_score_inc;
  logic              w_grant_nxt, w_lethal, w_clear, w_tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock  (clock),
    .resetn (resetn),
    .enable (r_state == ST_PLAY),
    .clear  (w_clear),
    .tick   (w_tick)
  );

  // State and status registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_score     <= '0;
      r_high      <= '0;
      r_health    <= '0;
      r_cool      <= '0;
      r_grant     <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_score     <= w_score_nxt;
      r_high      <= w_high_nxt;
      r_health    <= w_health_nxt;
      r_cool      <= w_cool_nxt;
      r_grant     <= w_grant_nxt;
      r_game_over <= (w_state_nxt == ST_OVER);
    end
  end

  // Score is bumped before the lethal check so a same-cycle kill counts toward high score.
  assign w_score_inc = score_evt ? sat_inc(r_score) : r_score;
  assign w_lethal    = damage_evt && (r_health <= 8'd1);

  // Next-state and status update; lethal damage takes priority over fire/tick.
  always_comb begin
    w_state_nxt  = r_state;
    w_score_nxt  = r_score;
    w_high_nxt   = r_high;
    w_health_nxt = r_health;
    w_cool_nxt   = r_cool;
    w_grant_nxt  = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        w_cool_nxt = '0;
        if (start) begin
          w_state_nxt  = ST_PLAY;
          w_score_nxt  = '0;
          w_health_nxt = HEALTH_INIT;
          w_clear      = 1'b1;
        end
      end
      ST_PLAY: begin
        w_score_nxt = w_score_inc;
        if (w_lethal) begin
          w_health_nxt = '0;
          w_state_nxt  = ST_OVER;
          w_cool_nxt   = '0;
          if (w_score_inc > r_high) w_high_nxt = w_score_inc;
        end else begin
          if (damage_evt) w_health_nxt = r_health - 1'b1;
          // A grant reloads even if a tick lands in the same cycle.
          if (fire_req && (r_cool == '0)) begin
            w_grant_nxt = 1'b1;
            w_cool_nxt  = COOL_LOAD;
          end else if (w_tick && (r_cool != '0)) begin
            w_cool_nxt  = r_cool - 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign fire_grant = r_grant;
  assign score      = r_score;
  assign high_score = r_high;
  assign health     = r_health;
  assign cooldown   = r_cool;
  assign state      = r_state;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_game_status_ctrl.sv
// Directed bench for game_status_ctrl (TICK_DIV=4, COOL_LOAD=2, HEALTH_INIT=FF).
module tb_game_status_ctrl;

  logic       clock = 1'b0;
  logic       resetn, start, score_evt, damage_evt, fire_req;
  logic       fire_grant, game_over;
  logic [7:0] score, high_score, health, cooldown;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  game_status_ctrl #(
    .TICK_DIV    (4),
    .COOL_LOAD   (8'd2),
    .HEALTH_INIT (8'hFF)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .score_evt  (score_evt),
    .damage_evt (damage_evt),
    .fire_req   (fire_req),
    .fire_grant (fire_grant),
    .score      (score),
    .high_score (high_score),
    .health     (health),
    .cooldown   (cooldown),
    .state      (state),
    .game_over  (game_over)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    resetn = 1'b0; start = 1'b0; score_evt = 1'b0; damage_evt = 1'b0; fire_req = 1'b0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic n_score(input int n);
    score_evt = 1'b1; repeat (n) @(posedge clock); #1 score_evt = 1'b0;
  endtask

  task automatic n_damage(input int n);
    damage_evt = 1'b1; repeat (n) @(posedge clock); #1 damage_evt = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if ({score, high_score, health, cooldown} !== 32'h0) begin errors++;
      $display("FAIL reset_regs: got %h %h %h %h want zeros", score, high_score, health, cooldown); end
    checks++; if ({fire_grant, game_over} !== 2'b00) begin errors++;
      $display("FAIL reset_flags: got %b%b want 00", fire_grant, game_over); end
  endtask

  task automatic test_start_score();
    do_reset();
    pulse_start();
    n_score(3);
    checks++; if (score !== 8'd3) begin errors++; $display("FAIL start_score: got %0d want 3", score); end
    checks++; if (health !== 8'hFF) begin errors++; $display("FAIL start_health: got %h want ff", health); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d want 1", state); end
    pulse_start();  // ignored while playing
    checks++; if (score !== 8'd3) begin errors++; $display("FAIL start_in_play: got %0d want 3", score); end
  endtask

  task automatic test_high_score_retention();
    do_reset();
    pulse_start();
    n_score(5);
    n_damage(5);
    checks++; if (health !== 8'hFA) begin errors++; $display("FAIL hs_health_dec: got %h want fa", health); end
    n_damage(250);
    checks++; if (state !== 2'd2 || game_over !== 1'b1) begin errors++;
      $display("FAIL hs_g1_over: got st=%0d go=%b want 2/1", state, game_over); end
    checks++; if (high_score !== 8'd5) begin errors++; $display("FAIL hs_g1_high: got %0d want 5", high_score); end
    pulse_start();
    checks++; if (score !== 8'd0 || high_score !== 8'd5 || game_over !== 1'b0) begin errors++;
      $display("FAIL hs_g2_start: got sc=%0d hi=%0d go=%b want 0/5/0", score, high_score, game_over); end
    n_score(3);
    n_damage(255);
    checks++; if (high_score !== 8'd5 || score !== 8'd3) begin errors++;
      $display("FAIL hs_g2_high: got hi=%0d sc=%0d want 5/3", high_score, score); end
  endtask

  task automatic test_saturation();
    do_reset();
    pulse_start();
    n_score(300);
    checks++; if (score !== 8'hFF) begin errors++; $display("FAIL sat_score: got %h want ff", score); end
    n_damage(254);
    checks++; if (health !== 8'd1 || state !== 2'd1) begin errors++;
      $display("FAIL sat_health1: got h=%0d st=%0d want 1/1", health, state); end
    n_damage(1);
    checks++; if (state !== 2'd2 || health !== 8'd0 || high_score !== 8'hFF) begin errors++;
      $display("FAIL sat_over: got st=%0d h=%0d hi=%h want 2/0/ff", state, health, high_score); end
  endtask

  task automatic test_simultaneous_lethal();
    do_reset();
    pulse_start();
    n_score(7);
    n_damage(254);
    score_evt = 1'b1; damage_evt = 1'b1; fire_req = 1'b1;
    @(posedge clock); #1;
    score_evt = 1'b0; damage_evt = 1'b0; fire_req = 1'b0;
    checks++; if (score !== 8'd8 || health !== 8'd0) begin errors++;
      $display("FAIL sim_regs: got sc=%0d h=%0d want 8/0", score, health); end
    checks++; if (state !== 2'd2 || game_over !== 1'b1 || high_score !== 8'd8) begin errors++;
      $display("FAIL sim_over: got st=%0d go=%b hi=%0d want 2/1/8", state, game_over, high_score); end
    checks++; if (fire_grant !== 1'b0 || cooldown !== 8'd0) begin errors++;
      $display("FAIL sim_grant: got g=%b cd=%0d want 0/0", fire_grant, cooldown); end
  endtask

  task automatic test_cooldown();
    logic [7:0] exp_cd [1:30];
    logic       exp_g;
    exp_cd = '{8'd2,8'd2,8'd2,8'd1,8'd1,8'd1,8'd1,8'd0,8'd2,8'd2,
               8'd2,8'd1,8'd1,8'd1,8'd1,8'd0,8'd2,8'd2,8'd2,8'd1,
               8'd1,8'd1,8'd1,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0};
    do_reset();
    fire_req = 1'b1;
    pulse_start();
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clock); #1;
      exp_g = (cyc == 1) || (cyc == 9) || (cyc == 17);
      checks++; if (fire_grant !== exp_g) begin errors++;
        $display("FAIL cd_grant c%0d: got %b want %b", cyc, fire_grant, exp_g); end
      checks++; if (cooldown !== exp_cd[cyc]) begin errors++;
        $display("FAIL cd_value c%0d: got %0d want %0d", cyc, cooldown, exp_cd[cyc]); end
      if (cyc == 18) fire_req = 1'b0;
    end
  endtask

  task automatic test_reset_midgame();
    do_reset();
    pulse_start();
    n_score(4);
    fire_req = 1'b1; @(posedge clock); #1 fire_req = 1'b0;
    checks++; if (cooldown !== 8'd2 || fire_grant !== 1'b1) begin errors++;
      $display("FAIL mid_pre: got cd=%0d g=%b want 2/1", cooldown, fire_grant); end
    #3 resetn = 1'b0;
    #1;
    checks++; if ({score, high_score, health, cooldown, state, fire_grant, game_over} !== 36'h0) begin errors++;
      $display("FAIL mid_async: got sc=%0d h=%0d cd=%0d st=%0d g=%b", score, health, cooldown, state, fire_grant); end
    #2 resetn = 1'b1;
    @(posedge clock); #1;
    pulse_start();
    checks++; if (health !== 8'hFF || state !== 2'd1) begin errors++;
      $display("FAIL mid_restart: got h=%h st=%0d want ff/1", health, state); end
  endtask

  initial begin
    test_reset();
    test_start_score();
    test_high_score_retention();
    test_saturation();
    test_simultaneous_lethal();
    test_cooldown();
    test_reset_midgame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
